gpu_cmd_scheduler: RTL and testbench
====================================

# gpu_cmd_scheduler

Sequences host read/write commands onto the shared GPU resource port (layer headers, layer RAM, palette) around frame render events. Writes arriving during a render are parked in an internal FIFO; reads bypass them and are serviced immediately. Parked writes drain once the render ends. The block signals when the next frame may start. It sits between the command buffer and the resource port.

## Interface
Parameters:
- AW, 16, resource address width
- DW, 16, data width
- WQ_DEPTH, 16, write FIFO depth (power of two, ≥2)

Ports:
- cmd_clk_in  in  1  single clock for the block
- cmd_rst_in  in  1  reset, asynchronous, active-high
- cmd_valid_in  in  1  command offered
- cmd_ready_out  out  1  command accepted when valid && ready
- cmd_write_in  in  1  1 = write, 0 = read
- cmd_addr_in  in  AW  command address
- cmd_wdata_in  in  DW  write data
- render_active_in  in  1  level; high for the duration of a frame render
- frame_ok_out  out  1  next render may start
- res_req_out  out  1  resource access request
- res_we_out  out  1  access is a write
- res_addr_out  out  AW  access address
- res_wdata_out  out  DW  access write data
- res_gnt_in  in  1  resource accepts the request this cycle
- res_rvalid_in  in  1  read data valid
- res_rdata_in  in  DW  read data
- rsp_valid_out  out  1  read response pulse
- rsp_data_out  out  DW  read response data

## Operation
- Writes are always enqueued into the FIFO, including writes outside a render. Accepted whenever the FIFO is not full, in any state.
- Reads are accepted only in IDLE and only when (render_active_in || fifo_empty).
  - During a render, reads bypass parked writes.
  - Outside a render, reads wait until all earlier writes have drained, which preserves write-then-read order.
- cmd_ready_out = cmd_write_in ? !fifo_full : (state==IDLE && (render_active_in || fifo_empty)).
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE → RD_REQ on read accept, which latches addr.
  - IDLE → WR_REQ when !render_active_in && !fifo_empty, which pops the FIFO head into the output regs. A read accept in the same cycle takes priority; this can only occur while rendering, when draining is disabled anyway.
  - RD_REQ: res_req_out=1, res_we_out=0. Goes to RD_WAIT on res_gnt_in.
  - RD_WAIT: goes to IDLE on res_rvalid_in, latching data. Exactly one outstanding read.
  - WR_REQ: res_req_out=1, res_we_out=1. Goes to IDLE on res_gnt_in.
- render_active_in rising while in WR_REQ: that write completes, then no further pops until render_active_in falls.
- frame_ok_out = !render_active_in && fifo_empty && state==IDLE, registered.
- Simultaneous FIFO push and pop when full is permitted: the pop frees space in the same cycle.
- FIFO pointers are log2(WQ_DEPTH)+1 bits; full/empty come from MSB compare.

## Timing
- Reset values: cmd_ready_out combinational (→1 for a write and for a read, since the FIFO is empty); frame_ok_out 0 (1 from the first cycle after reset if render inactive); res_req_out 0, res_we_out 0, res_addr_out 0, res_wdata_out 0, rsp_valid_out 0, rsp_data_out 0; FIFO empty; state IDLE.
- Asserting reset mid-access drops res_req_out immediately. Parked writes are discarded, and a pending read response is never issued.
- Read accepted at cycle N → res_req_out high at N+1, held until the res_gnt_in cycle. rsp_valid_out is a one-cycle pulse in the cycle after res_rvalid_in.
- Write accepted at N with render inactive and the FSM in IDLE → res_req_out high at N+2 (the push lands at N+1, the pop occurs at N+1).
- Back-to-back drain: one write per 2 cycles with res_gnt_in tied high.
- Request outputs change only on a clock edge. Once asserted, res_req_out and its addr/data stay stable until granted.

## Structure
- Shared package gpu_pkg holds the FSM state encoding (IDLE=0, RD_REQ=1, RD_WAIT=2, WR_REQ=3) and the write-entry struct/width constant {addr, data} = AW+DW.
- Sub-module gpu_cmd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, and asynchronous reset.

## Test plan
- Idle write: render low, write addr 0x0012 data 0xBEEF → res_req at +2 cycles with we=1 and correct addr/data; frame_ok returns to 1 after grant.
- Read bypass: render high; write palette 0x0305=0x7777 then read 0x0305 (resource holds 0x1111) → rsp_data 0x1111; the write is issued only after render falls, and frame_ok stays 0 until it is granted.
- Ordering outside render: queue 3 writes, then a read of the last address → read is not accepted until the FIFO is empty; rsp returns the newly written value.
- Full: render high, push 16 writes → cmd_ready low for a 17th write while a read is still accepted; all 16 drain in order after render falls.
- Grant stall: hold res_gnt low for 5 cycles in WR_REQ → addr/data stable, no pop; render rising during the stall → exactly that one write completes.
- Reset mid-RD_WAIT with 4 parked writes → outputs at reset values, no rsp pulse, FIFO empty.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the GPU command scheduler: FSM encoding and parked-write entry layout.
package gpu_pkg;

  localparam int unsigned GPU_AW     = 16;
  localparam int unsigned GPU_DW     = 16;
  localparam int unsigned WR_ENTRY_W = GPU_AW + GPU_DW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [GPU_AW-1:0] addr;
    logic [GPU_DW-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/gpu_cmd_scheduler_if.sv
// Command-buffer and resource-port signal bundle around the scheduler.
interface gpu_cmd_scheduler_if
  import gpu_pkg::*;
#(
  parameter int unsigned AW = GPU_AW,
  parameter int unsigned DW = GPU_DW
);

  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic          cmd_write_in;
  logic [AW-1:0] cmd_addr_in;
  logic [DW-1:0] cmd_wdata_in;
  logic          render_active_in;
  logic          frame_ok_out;
  logic          res_req_out;
  logic          res_we_out;
  logic [AW-1:0] res_addr_out;
  logic [DW-1:0] res_wdata_out;
  logic          res_gnt_in;
  logic          res_rvalid_in;
  logic [DW-1:0] res_rdata_in;
  logic          rsp_valid_out;
  logic [DW-1:0] rsp_data_out;

  modport slave (
    input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, render_active_in,
           res_gnt_in, res_rvalid_in, res_rdata_in,
    output cmd_ready_out, frame_ok_out, res_req_out, res_we_out, res_addr_out,
           res_wdata_out, rsp_valid_out, rsp_data_out
  );

  modport master (
    output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, render_active_in,
           res_gnt_in, res_rvalid_in, res_rdata_in,
    input  cmd_ready_out, frame_ok_out, res_req_out, res_we_out, res_addr_out,
           res_wdata_out, rsp_valid_out, rsp_data_out
  );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO holding parked writes; extra pointer MSB separates full from empty.
module gpu_cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;

  logic [PTRW-1:0]  wr_ptr_q;
  logic [PTRW-1:0]  rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop_c  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push_c = push_i && (!full_o || do_pop_c);
  assign dout_o    = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Orders host reads/writes onto the GPU resource port; writes park during a render,
// reads bypass them, and parked writes drain once the render ends.
module gpu_cmd_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned AW       = GPU_AW,
  parameter int unsigned DW       = GPU_DW,
  parameter int unsigned WQ_DEPTH = 16
) (
  input  logic               cmd_clk_in,
  input  logic               cmd_rst_in,
  gpu_cmd_scheduler_if.slave bus
);

  localparam int unsigned EW = AW + DW;

  sched_state_e  state_q;
  logic          res_req_q;
  logic          res_we_q;
  logic [AW-1:0] res_addr_q;
  logic [DW-1:0] res_wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          frame_ok_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_head;
  logic          cmd_ready_c;
  logic          push_c;
  logic          rd_accept_c;
  logic          pop_c;

  // Outside a render a read waits for the FIFO to empty so it observes earlier writes.
  assign cmd_ready_c = bus.cmd_write_in ? !fifo_full
                                        : ((state_q == IDLE) && (bus.render_active_in || fifo_empty));
  assign push_c      = bus.cmd_valid_in && cmd_ready_c && bus.cmd_write_in;
  assign rd_accept_c = bus.cmd_valid_in && cmd_ready_c && !bus.cmd_write_in;
  assign pop_c       = (state_q == IDLE) && !rd_accept_c && !bus.render_active_in && !fifo_empty;

  gpu_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (WQ_DEPTH)
  ) u_fifo (
    .clk_i   (cmd_clk_in),
    .rst_i   (cmd_rst_in),
    .push_i  (push_c),
    .din_i   ({bus.cmd_addr_in, bus.cmd_wdata_in}),
    .pop_i   (pop_c),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Access sequencer; request/address/data are loaded on entry and held until grant.
  always_ff @(posedge cmd_clk_in or posedge cmd_rst_in) begin
    if (cmd_rst_in) begin
      state_q     <= IDLE;
      res_req_q   <= 1'b0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      frame_ok_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      frame_ok_q  <= !bus.render_active_in && fifo_empty && (state_q == IDLE);
      case (state_q)
        IDLE: begin
          if (rd_accept_c) begin
            state_q    <= RD_REQ;
            res_req_q  <= 1'b1;
            res_we_q   <= 1'b0;
            res_addr_q <= bus.cmd_addr_in;
          end else if (pop_c) begin
            state_q     <= WR_REQ;
            res_req_q   <= 1'b1;
            res_we_q    <= 1'b1;
            res_addr_q  <= fifo_head[EW-1:DW];
            res_wdata_q <= fifo_head[DW-1:0];
          end
        end
        RD_REQ: begin
          if (bus.res_gnt_in) begin
            state_q   <= RD_WAIT;
            res_req_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bus.res_rvalid_in) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.res_rdata_in;
          end
        end
        WR_REQ: begin
          if (bus.res_gnt_in) begin
            state_q   <= IDLE;
            res_req_q <= 1'b0;
            res_we_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_out = cmd_ready_c;
  assign bus.frame_ok_out  = frame_ok_q;
  assign bus.res_req_out   = res_req_q;
  assign bus.res_we_out    = res_we_q;
  assign bus.res_addr_out  = res_addr_q;
  assign bus.res_wdata_out = res_wdata_q;
  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_data_out  = rsp_data_q;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Randomised and directed bench for gpu_cmd_scheduler against a transaction-level model.
module tb_gpu_cmd_scheduler;
  import gpu_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  gpu_cmd_scheduler_if #(.AW(AW), .DW(DW)) bus ();

  gpu_cmd_scheduler #(.AW(AW), .DW(DW), .WQ_DEPTH(DEPTH)) dut (
    .cmd_clk_in (clk),
    .cmd_rst_in (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- resource emulation ----------------
  logic [15:0] rmem [logic [15:0]];
  logic [15:0] wlog_addr [$];
  logic [15:0] wlog_data [$];
  int          gnt_mode = 0;   // 0 random, 1 tied high, 2 held low
  bit          rv_block = 0;
  bit          rd_pend  = 0;
  int          rd_delay = 0;
  logic [15:0] rd_addr_p;

  function automatic logic [15:0] rmem_rd(input logic [15:0] a);
    if (rmem.exists(a)) return rmem[a];
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (rst) rd_pend = 0;
    else if (bus.res_req_out && bus.res_gnt_in) begin
      if (bus.res_we_out) begin
        rmem[bus.res_addr_out] = bus.res_wdata_out;
        wlog_addr.push_back(bus.res_addr_out);
        wlog_data.push_back(bus.res_wdata_out);
      end else begin
        rd_pend   = 1;
        rd_delay  = int'($urandom_range(0, 3));
        rd_addr_p = bus.res_addr_out;
      end
    end
    #1;
    bus.res_rvalid_in = 1'b0;
    bus.res_rdata_in  = 16'($urandom);
    if (rd_pend && !rv_block && !rst) begin
      if (rd_delay == 0) begin
        bus.res_rvalid_in = 1'b1;
        bus.res_rdata_in  = rmem_rd(rd_addr_p);
        rd_pend = 0;
      end else rd_delay--;
    end
    case (gnt_mode)
      1:       bus.res_gnt_in = 1'b1;
      2:       bus.res_gnt_in = 1'b0;
      default: bus.res_gnt_in = ($urandom_range(0, 99) < 60);
    endcase
  end

  // ---------------- behavioural model ----------------
  wr_entry_t   mq [$];
  wr_entry_t   m_e;
  bit          acc_on = 0, acc_we = 0, acc_granted = 0;
  logic [15:0] acc_addr = '0, acc_data = '0;
  bit          exp_rsp_v = 0, exp_fok = 0;
  logic [15:0] exp_rsp_d = '0;
  bit          m_fire_w, m_fire_r, m_fok;

  function automatic bit m_ready();
    if (bus.cmd_write_in) return mq.size() < DEPTH;
    return !acc_on && (bus.render_active_in || mq.size() == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      acc_on = 0; acc_we = 0; acc_granted = 0;
      exp_rsp_v = 0; exp_fok = 0;
    end else begin
      m_fire_w  = bus.cmd_valid_in && bus.cmd_write_in && (mq.size() < DEPTH);
      m_fire_r  = bus.cmd_valid_in && !bus.cmd_write_in && !acc_on &&
                  (bus.render_active_in || mq.size() == 0);
      m_fok     = !bus.render_active_in && (mq.size() == 0) && !acc_on;
      exp_rsp_v = 0;
      if (!acc_on) begin
        if (m_fire_r) begin
          acc_on = 1; acc_we = 0; acc_granted = 0; acc_addr = bus.cmd_addr_in;
        end else if (!bus.render_active_in && mq.size() != 0) begin
          m_e = mq.pop_front();
          acc_on = 1; acc_we = 1; acc_granted = 0; acc_addr = m_e.addr; acc_data = m_e.data;
        end
      end else if (!acc_granted) begin
        if (bus.res_gnt_in) begin
          if (acc_we) acc_on = 0;
          else        acc_granted = 1;
        end
      end else if (bus.res_rvalid_in) begin
        acc_on = 0; exp_rsp_v = 1; exp_rsp_d = bus.res_rdata_in;
      end
      if (m_fire_w) mq.push_back('{addr: bus.cmd_addr_in, data: bus.cmd_wdata_in});
      exp_fok = m_fok;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(bus.cmd_ready_out), 32'(m_ready()));
      check("res_req", 32'(bus.res_req_out), 32'(acc_on && !acc_granted));
      if (acc_on && !acc_granted) begin
        check("res_we", 32'(bus.res_we_out), 32'(acc_we));
        check("res_addr", 32'(bus.res_addr_out), 32'(acc_addr));
        if (acc_we) check("res_wdata", 32'(bus.res_wdata_out), 32'(acc_data));
      end
      check("rsp_valid", 32'(bus.rsp_valid_out), 32'(exp_rsp_v));
      if (exp_rsp_v) check("rsp_data", 32'(bus.rsp_data_out), 32'(exp_rsp_d));
      check("frame_ok", 32'(bus.frame_ok_out), 32'(exp_fok));
    end
  end

  int          rsp_cnt = 0;
  logic [15:0] last_rsp = '0;
  always @(negedge clk) begin
    if (bus.rsp_valid_out) begin
      rsp_cnt++;
      last_rsp = bus.rsp_data_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit we, input logic [15:0] a, input logic [15:0] d);
    bit done;
    done = 0;
    bus.cmd_valid_in = 1'b1; bus.cmd_write_in = we;
    bus.cmd_addr_in  = a;    bus.cmd_wdata_in = d;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (bus.cmd_ready_out) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 32'(0), 32'(1));
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mq.size() != 0 || acc_on) && n < 500) begin tick(); n++; end
    if (n >= 500) check("idle_timeout", 32'(0), 32'(1));
    tick();
  endtask

  task automatic wait_rsp(input int start);
    int n;
    n = 0;
    while (rsp_cnt == start && n < 200) begin tick(); n++; end
    if (n >= 200) check("rsp_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  logic [15:0] vals [16];
  int          base, start;

  initial begin
    bus.cmd_valid_in = 0; bus.cmd_write_in = 0; bus.cmd_addr_in = '0; bus.cmd_wdata_in = '0;
    bus.render_active_in = 0; bus.res_gnt_in = 0; bus.res_rvalid_in = 0; bus.res_rdata_in = '0;
    #1 rst = 1;
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_frame_ok", 32'(bus.frame_ok_out), 32'(0));
    check("rst_ready_wr", 32'(bus.cmd_ready_out), 32'(1));
    check("rst_res_we", 32'(bus.res_we_out), 32'(0));
    check("rst_res_addr", 32'(bus.res_addr_out), 32'(0));
    check("rst_res_wdata", 32'(bus.res_wdata_out), 32'(0));
    check("rst_rsp_data", 32'(bus.rsp_data_out), 32'(0));
    tick(); tick();
    rst = 0;
    tick();
    @(negedge clk);
    check("post_rst_frame_ok", 32'(bus.frame_ok_out), 32'(1));

    // Idle write latency and fields
    gnt_mode = 2; tick();
    send(1, 16'h0012, 16'hBEEF);
    @(negedge clk);
    check("idle_wr_req_n1", 32'(bus.res_req_out), 32'(0));
    tick();
    @(negedge clk);
    check("idle_wr_req_n2", 32'(bus.res_req_out), 32'(1));
    check("idle_wr_we", 32'(bus.res_we_out), 32'(1));
    check("idle_wr_addr", 32'(bus.res_addr_out), 32'h0012);
    check("idle_wr_data", 32'(bus.res_wdata_out), 32'hBEEF);
    gnt_mode = 1;
    repeat (4) tick();
    check("idle_wr_mem", 32'(rmem_rd(16'h0012)), 32'hBEEF);
    check("idle_wr_frame_ok", 32'(bus.frame_ok_out), 32'(1));

    // Read bypasses a parked write during render
    gnt_mode = 0;
    rmem[16'h0305] = 16'h1111;
    bus.render_active_in = 1; tick();
    send(1, 16'h0305, 16'h7777);
    start = rsp_cnt;
    send(0, 16'h0305, 16'h0000);
    wait_rsp(start);
    check("bypass_rsp", 32'(last_rsp), 32'h1111);
    repeat (4) tick();
    check("bypass_no_early_wr", 32'(rmem_rd(16'h0305)), 32'h1111);
    check("bypass_frame_ok", 32'(bus.frame_ok_out), 32'(0));
    bus.render_active_in = 0;
    wait_idle(); tick();
    check("bypass_drained", 32'(rmem_rd(16'h0305)), 32'h7777);
    check("bypass_frame_ok_end", 32'(bus.frame_ok_out), 32'(1));

    // Write-then-read ordering outside a render
    for (int i = 0; i < 3; i++) begin
      vals[i] = 16'($urandom);
      send(1, 16'h0040 + 16'(i), vals[i]);
    end
    bus.cmd_valid_in = 1; bus.cmd_write_in = 0; bus.cmd_addr_in = 16'h0042;
    @(negedge clk);
    check("order_rd_blocked", 32'(bus.cmd_ready_out), 32'(0));
    start = rsp_cnt;
    send(0, 16'h0042, 16'h0000);
    wait_rsp(start);
    check("order_rsp", 32'(last_rsp), 32'(vals[2]));
    wait_idle();

    // Full FIFO during render
    bus.render_active_in = 1; tick();
    base = wlog_addr.size();
    for (int i = 0; i < 16; i++) begin
      vals[i] = 16'($urandom);
      send(1, 16'h0100 + 16'(i), vals[i]);
    end
    bus.cmd_valid_in = 1; bus.cmd_write_in = 1; bus.cmd_addr_in = 16'h01FF;
    @(negedge clk);
    check("full_wr_blocked", 32'(bus.cmd_ready_out), 32'(0));
    bus.cmd_write_in = 0; bus.cmd_addr_in = 16'h0150;
    #1;
    check("full_rd_ready", 32'(bus.cmd_ready_out), 32'(1));
    start = rsp_cnt;
    send(0, 16'h0150, 16'h0000);
    wait_rsp(start);
    bus.render_active_in = 0;
    wait_idle();
    check("full_drain_cnt", 32'(wlog_addr.size() - base), 32'(16));
    for (int i = 0; i < 16 && base + i < wlog_addr.size(); i++) begin
      check("full_drain_addr", 32'(wlog_addr[base + i]), 32'h0100 + 32'(i));
      check("full_drain_data", 32'(wlog_data[base + i]), 32'(vals[i]));
    end

    // Grant stall with render rising mid-stall
    gnt_mode = 2; tick();
    base = wlog_addr.size();
    vals[0] = 16'($urandom); vals[1] = 16'($urandom);
    send(1, 16'h0200, vals[0]);
    send(1, 16'h0201, vals[1]);
    for (int n = 0; n < 20 && !bus.res_req_out; n++) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", 32'(bus.res_req_out), 32'(1));
      check("stall_addr", 32'(bus.res_addr_out), 32'h0200);
      check("stall_data", 32'(bus.res_wdata_out), 32'(vals[0]));
      if (i == 2) bus.render_active_in = 1;
      tick();
    end
    gnt_mode = 1;
    repeat (6) tick();
    check("stall_one_write", 32'(wlog_addr.size() - base), 32'(1));
    check("stall_no_req", 32'(bus.res_req_out), 32'(0));
    bus.render_active_in = 0;
    wait_idle();
    check("stall_second_write", 32'(wlog_addr.size() - base), 32'(2));

    // Reset while a read is outstanding with parked writes
    bus.render_active_in = 1; tick();
    for (int i = 0; i < 4; i++) send(1, 16'h0300 + 16'(i), 16'($urandom));
    rv_block = 1;
    send(0, 16'h0310, 16'h0000);
    repeat (3) tick();
    base  = wlog_addr.size();
    start = rsp_cnt;
    rst = 1;
    @(negedge clk);
    check("rst_mid_req", 32'(bus.res_req_out), 32'(0));
    check("rst_mid_rsp", 32'(bus.rsp_valid_out), 32'(0));
    check("rst_mid_frame_ok", 32'(bus.frame_ok_out), 32'(0));
    tick(); tick();
    rst = 0; bus.render_active_in = 0;
    tick();
    rv_block = 0;
    repeat (10) tick();
    check("rst_no_writes", 32'(wlog_addr.size() - base), 32'(0));
    check("rst_no_rsp", 32'(rsp_cnt - start), 32'(0));
    check("rst_frame_ok_back", 32'(bus.frame_ok_out), 32'(1));

    // Random traffic
    gnt_mode = 0;
    for (int c = 0; c < 800; c++) begin
      bus.cmd_valid_in = 1'($urandom_range(0, 1));
      bus.cmd_write_in = ($urandom_range(0, 99) < 60);
      bus.cmd_addr_in  = 16'h0400 + 16'($urandom_range(0, 7));
      bus.cmd_wdata_in = 16'($urandom);
      if ($urandom_range(0, 29) == 0) bus.render_active_in = !bus.render_active_in;
      tick();
    end
    bus.cmd_valid_in = 0; bus.render_active_in = 0;
    wait_idle();
    repeat (3) tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
